// File: rtl/mem_stage_pkg.sv
// Shared header for the memory-access stage: bus layouts, widths and load_op codes.
package mem_stage_pkg;

    localparam int unsigned DATA_WD  = 32;
    localparam int unsigned DEST_WD  = 5;
    localparam int unsigned LOP_WD   = 3;

    localparam logic [LOP_WD-1:0] LOP_NONE = 3'd0;
    localparam logic [LOP_WD-1:0] LOP_LB   = 3'd1;
    localparam logic [LOP_WD-1:0] LOP_LBU  = 3'd2;
    localparam logic [LOP_WD-1:0] LOP_LH   = 3'd3;
    localparam logic [LOP_WD-1:0] LOP_LHU  = 3'd4;
    localparam logic [LOP_WD-1:0] LOP_LW   = 3'd5;

    typedef struct packed {
        logic               inst2_valid;
        logic               inst2_gr_we;
        logic [DEST_WD-1:0] inst2_dest;
        logic [DATA_WD-1:0] inst2_alu_result;
        logic [DATA_WD-1:0] inst2_pc;
        logic               inst1_mem_req;
        logic [LOP_WD-1:0]  inst1_load_op;
        logic               inst1_gr_we;
        logic [DEST_WD-1:0] inst1_dest;
        logic [DATA_WD-1:0] inst1_alu_result;
        logic [DATA_WD-1:0] inst1_pc;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic               inst2_valid;
        logic               inst2_gr_we;
        logic [DEST_WD-1:0] inst2_dest;
        logic [DATA_WD-1:0] inst2_final_result;
        logic [DATA_WD-1:0] inst2_pc;
        logic               inst1_gr_we;
        logic [DEST_WD-1:0] inst1_dest;
        logic [DATA_WD-1:0] inst1_final_result;
        logic [DATA_WD-1:0] inst1_pc;
    } ms_to_ws_bus_t;

    // Field order seen by decode; ms_valid is the MSB.
    typedef struct packed {
        logic               ms_valid;
        logic               inst1_gr_we;
        logic [DEST_WD-1:0] inst1_dest;
        logic [DATA_WD-1:0] inst1_final_result;
        logic               inst1_fwd_ok;
        logic               inst2_we;
        logic [DEST_WD-1:0] inst2_dest;
        logic [DATA_WD-1:0] inst2_final_result;
    } ms_forward_bus_t;

    localparam int unsigned ES_TO_MS_BUS_WD   = $bits(es_to_ms_bus_t);
    localparam int unsigned MS_TO_WS_BUS_WD   = $bits(ms_to_ws_bus_t);
    localparam int unsigned MS_FORWARD_BUS_WD = $bits(ms_forward_bus_t);

endpackage

// File: rtl/mem_stage_if.sv
// Handshake, payload and data-SRAM response signals around the memory-access stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            es_to_ms_valid;
    es_to_ms_bus_t   es_to_ms_bus;
    logic            ms_allowin;
    logic            ws_allowin;
    logic            ms_to_ws_valid;
    ms_to_ws_bus_t   ms_to_ws_bus;
    logic            data_sram_data_ok;
    logic [31:0]     data_sram_rdata;
    ms_forward_bus_t ms_forward_bus;

    modport master (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward_bus
    );

    modport slave (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward_bus
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half of a little-endian load word and extends it to 32 bits.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [DATA_WD-1:0] raw_word,
    input  logic [1:0]         addr,
    input  logic [LOP_WD-1:0]  load_op,
    output logic [DATA_WD-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? raw_word[31:16] : raw_word[15:0];
        case (load_op)
            LOP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LOP_LBU: result = {24'h000000, byte_sel};
            LOP_LH:  result = {{16{half_sel[15]}}, half_sel};
            LOP_LHU: result = {16'h0000, half_sel};
            default: result = raw_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction pair, waits for slot-1 load data, forwards results.
// Optional feature macro: MS_FWD_LOAD_EN (forward load data to decode in the data_ok cycle).
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mem_stage_if.master     ms
);

    logic               ms_valid;
    logic               buf_valid;
    es_to_ms_bus_t      es_r;
    logic [DATA_WD-1:0] rdata_buf;

    logic               wait_data;
    logic               data_ok_take;
    logic               ms_ready_go;
    logic               pair_leaves;
    logic               inst1_fwd_ok;
    logic [DATA_WD-1:0] raw_word;
    logic [DATA_WD-1:0] load_result;
    logic [DATA_WD-1:0] inst1_final_result;
    logic [DATA_WD-1:0] fwd_inst1_result;

    // A response only counts while a load is pending and nothing is buffered yet.
    assign wait_data    = ms_valid & es_r.inst1_mem_req & (es_r.inst1_load_op != LOP_NONE);
    assign data_ok_take = ms.data_sram_data_ok & wait_data & ~buf_valid;
    assign ms_ready_go  = ~wait_data | data_ok_take | buf_valid;

    assign ms.ms_allowin     = ~ms_valid | (ms_ready_go & ms.ws_allowin);
    assign ms.ms_to_ws_valid = ms_valid & ms_ready_go;
    assign pair_leaves       = ms.ms_to_ws_valid & ms.ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            buf_valid <= 1'b0;
        end else begin
            if (ms.ms_allowin) begin
                ms_valid <= ms.es_to_ms_valid;
            end
            if (pair_leaves) begin
                buf_valid <= 1'b0;
            end else if (data_ok_take & ~ms.ws_allowin) begin
                buf_valid <= 1'b1;
            end
        end
    end

    // Payload registers carry no reset; ms_valid/buf_valid qualify them.
    always_ff @(posedge clk) begin
        if (ms.es_to_ms_valid & ms.ms_allowin) begin
            es_r <= ms.es_to_ms_bus;
        end
        if (data_ok_take & ~ms.ws_allowin) begin
            rdata_buf <= ms.data_sram_rdata;
        end
    end

    assign raw_word = buf_valid ? rdata_buf : ms.data_sram_rdata;

    mem_stage_load_align u_load_align (
        .raw_word (raw_word),
        .addr     (es_r.inst1_alu_result[1:0]),
        .load_op  (es_r.inst1_load_op),
        .result   (load_result)
    );

    assign inst1_final_result = wait_data ? load_result : es_r.inst1_alu_result;

`ifdef MS_FWD_LOAD_EN
    assign inst1_fwd_ok     = ~wait_data | data_ok_take | buf_valid;
    assign fwd_inst1_result = inst1_final_result;
`else
    // Decode never consumes load data from here, so keep rdata off the forward path.
    assign inst1_fwd_ok     = ~wait_data;
    assign fwd_inst1_result = es_r.inst1_alu_result;
`endif

    always_comb begin
        ms.ms_to_ws_bus.inst2_valid        = es_r.inst2_valid;
        ms.ms_to_ws_bus.inst2_gr_we        = es_r.inst2_gr_we;
        ms.ms_to_ws_bus.inst2_dest         = es_r.inst2_dest;
        ms.ms_to_ws_bus.inst2_final_result = es_r.inst2_alu_result;
        ms.ms_to_ws_bus.inst2_pc           = es_r.inst2_pc;
        ms.ms_to_ws_bus.inst1_gr_we        = es_r.inst1_gr_we;
        ms.ms_to_ws_bus.inst1_dest         = es_r.inst1_dest;
        ms.ms_to_ws_bus.inst1_final_result = inst1_final_result;
        ms.ms_to_ws_bus.inst1_pc           = es_r.inst1_pc;
    end

    always_comb begin
        ms.ms_forward_bus.ms_valid           = ms_valid;
        ms.ms_forward_bus.inst1_gr_we        = es_r.inst1_gr_we;
        ms.ms_forward_bus.inst1_dest         = es_r.inst1_dest;
        ms.ms_forward_bus.inst1_final_result = fwd_inst1_result;
        ms.ms_forward_bus.inst1_fwd_ok       = inst1_fwd_ok;
        ms.ms_forward_bus.inst2_we           = es_r.inst2_gr_we & es_r.inst2_valid;
        ms.ms_forward_bus.inst2_dest         = es_r.inst2_dest;
        ms.ms_forward_bus.inst2_final_result = es_r.inst2_alu_result;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back pairs queued at issue, compared on handoff.
module tb_mem_stage;
    import mem_stage_pkg::*;

`ifdef MS_FWD_LOAD_EN
    localparam logic FWD_LOAD = 1'b1;
`else
    localparam logic FWD_LOAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if ifc ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .ms    (ifc)
    );

    int errors = 0;
    int checks = 0;
    ms_to_ws_bus_t sb[$];

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> {a, 3'b000};
        h = w >> {a[1], 4'b0000};
        case (op)
            3'd1:    return {{24{b[7]}}, b[7:0]};
            3'd2:    return {24'h0, b[7:0]};
            3'd3:    return {{16{h[15]}}, h[15:0]};
            3'd4:    return {16'h0, h[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic es_to_ms_bus_t mk(input logic [4:0] d1, input logic [31:0] r1,
                                         input logic [4:0] d2, input logic [31:0] r2,
                                         input logic mreq, input logic [2:0] op);
        es_to_ms_bus_t e;
        e.inst2_valid      = 1'b1;
        e.inst2_gr_we      = 1'b1;
        e.inst2_dest       = d2;
        e.inst2_alu_result = r2;
        e.inst2_pc         = $urandom;
        e.inst1_mem_req    = mreq;
        e.inst1_load_op    = op;
        e.inst1_gr_we      = 1'b1;
        e.inst1_dest       = d1;
        e.inst1_alu_result = r1;
        e.inst1_pc         = $urandom;
        return e;
    endfunction

    function automatic ms_to_ws_bus_t exp_of(input es_to_ms_bus_t e, input logic [31:0] word);
        ms_to_ws_bus_t m;
        m.inst2_valid        = e.inst2_valid;
        m.inst2_gr_we        = e.inst2_gr_we;
        m.inst2_dest         = e.inst2_dest;
        m.inst2_final_result = e.inst2_alu_result;
        m.inst2_pc           = e.inst2_pc;
        m.inst1_gr_we        = e.inst1_gr_we;
        m.inst1_dest         = e.inst1_dest;
        m.inst1_final_result = (e.inst1_mem_req && e.inst1_load_op != 3'd0)
                               ? ext(e.inst1_load_op, e.inst1_alu_result[1:0], word)
                               : e.inst1_alu_result;
        m.inst1_pc           = e.inst1_pc;
        return m;
    endfunction

    // Every pair handed to write-back must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && ifc.ms_to_ws_valid && ifc.ws_allowin) begin
            check_eq("sb_nonempty", 192'(sb.size() != 0), 192'(1));
            if (sb.size() != 0) check_eq("wb_bus", 192'(ifc.ms_to_ws_bus), 192'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input es_to_ms_bus_t e, input logic [31:0] word);
        ifc.es_to_ms_valid = 1'b1;
        ifc.es_to_ms_bus   = e;
        sb.push_back(exp_of(e, word));
        @(negedge clk);
        check_eq("accept", 192'(ifc.ms_allowin), 192'(1));
        tick();
        ifc.es_to_ms_valid = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] word,
                           input int delay, input int stall);
        es_to_ms_bus_t e;
        logic [31:0]   r1;
        r1      = $urandom;
        r1[1:0] = a;
        e = mk(5'($urandom_range(1, 31)), r1, 5'($urandom_range(1, 31)), $urandom, 1'b1, op);
        send(e, word);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check_eq("busy_allowin", 192'(ifc.ms_allowin), 192'(0));
            check_eq("busy_valid", 192'(ifc.ms_to_ws_valid), 192'(0));
            check_eq("busy_fwd_ok", 192'(ifc.ms_forward_bus.inst1_fwd_ok), 192'(0));
            tick();
            ifc.data_sram_rdata = $urandom;
        end
        if (stall > 0) ifc.ws_allowin = 1'b0;
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = word;
        @(negedge clk);
        check_eq("dok_valid", 192'(ifc.ms_to_ws_valid), 192'(1));
        check_eq("dok_allowin", 192'(ifc.ms_allowin), 192'(stall == 0));
        check_eq("dok_fwd_ok", 192'(ifc.ms_forward_bus.inst1_fwd_ok), 192'(FWD_LOAD));
`ifdef MS_FWD_LOAD_EN
        check_eq("dok_fwd_data", 192'(ifc.ms_forward_bus.inst1_final_result), 192'(ext(op, a, word)));
`endif
        tick();
        ifc.data_sram_data_ok = 1'b0;
        ifc.data_sram_rdata   = $urandom;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("buf_valid_set", 192'(dut.buf_valid), 192'(1));
            check_eq("held_valid", 192'(ifc.ms_to_ws_valid), 192'(1));
            check_eq("held_allowin", 192'(ifc.ms_allowin), 192'(0));
            check_eq("held_fwd_ok", 192'(ifc.ms_forward_bus.inst1_fwd_ok), 192'(FWD_LOAD));
            tick();
            ifc.data_sram_rdata = $urandom;
        end
        if (stall > 0) begin
            ifc.ws_allowin = 1'b1;
            @(negedge clk);
            check_eq("release_allowin", 192'(ifc.ms_allowin), 192'(1));
            tick();
        end
        @(negedge clk);
        check_eq("after_valid", 192'(ifc.ms_to_ws_valid), 192'(0));
        check_eq("after_buf", 192'(dut.buf_valid), 192'(0));
        tick();
    endtask

    initial begin
        es_to_ms_bus_t e;
        es_to_ms_bus_t e2;
        int            budget;

        reset                 = 1'b1;
        ifc.es_to_ms_valid    = 1'b0;
        ifc.es_to_ms_bus      = '0;
        ifc.ws_allowin        = 1'b1;
        ifc.data_sram_data_ok = 1'b0;
        ifc.data_sram_rdata   = '0;
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_to_ws_valid", 192'(ifc.ms_to_ws_valid), 192'(0));
        check_eq("rst_allowin", 192'(ifc.ms_allowin), 192'(1));
        check_eq("rst_fwd_msb", 192'(ifc.ms_forward_bus.ms_valid), 192'(0));
        check_eq("rst_buf", 192'(dut.buf_valid), 192'(0));
        tick();
        reset = 1'b0;

        // Plain ALU pair.
        e = mk(5'd3, 32'h11, 5'd4, 32'h22, 1'b0, 3'd0);
        send(e, 32'h0);
        @(negedge clk);
        check_eq("alu_valid", 192'(ifc.ms_to_ws_valid), 192'(1));
        check_eq("alu_allowin", 192'(ifc.ms_allowin), 192'(1));
        check_eq("alu_fwd_msb", 192'(ifc.ms_forward_bus.ms_valid), 192'(1));
        check_eq("alu_fwd_ok", 192'(ifc.ms_forward_bus.inst1_fwd_ok), 192'(1));
        check_eq("alu_fwd_r1", 192'(ifc.ms_forward_bus.inst1_final_result), 192'(32'h11));
        check_eq("alu_fwd_r2", 192'(ifc.ms_forward_bus.inst2_final_result), 192'(32'h22));
        check_eq("alu_fwd_d2", 192'(ifc.ms_forward_bus.inst2_dest), 192'(5'd4));
        tick();
        @(negedge clk);
        check_eq("alu_drained", 192'(ifc.ms_to_ws_valid), 192'(0));
        tick();

        // Store: memory request without a load, never waits.
        e = mk(5'd7, 32'h1000_0004, 5'd8, 32'h5a5a, 1'b1, 3'd0);
        send(e, 32'h0);
        @(negedge clk);
        check_eq("store_valid", 192'(ifc.ms_to_ws_valid), 192'(1));
        tick();

        // Directed alignment cases.
        do_load(3'd1, 2'd2, 32'h1280_3456, 3, 0);
        do_load(3'd2, 2'd2, 32'h1280_3456, 3, 0);
        do_load(3'd3, 2'd2, 32'h8001_7FFF, 1, 0);
        do_load(3'd4, 2'd2, 32'h8001_7FFF, 0, 0);
        do_load(3'd5, 2'd0, 32'h8001_7FFF, 2, 0);
        do_load(3'd6, 2'd1, 32'hCAFE_BABE, 0, 0);
        do_load(3'd7, 2'd3, 32'hDEAD_BEEF, 1, 0);

        // Write-back stalled on the response: word buffered, later rdata ignored.
        do_load(3'd1, 2'd3, 32'h80FF_0000, 1, 2);
        do_load(3'd5, 2'd0, 32'h1234_5678, 0, 2);

        // Next pair offered while a load waits: held off until the load leaves.
        e  = mk(5'd9, 32'h2000_0000, 5'd10, 32'h33, 1'b1, 3'd5);
        e2 = mk(5'd11, 32'h44, 5'd12, 32'h55, 1'b0, 3'd0);
        send(e, 32'h0BAD_F00D);
        ifc.es_to_ms_valid = 1'b1;
        ifc.es_to_ms_bus   = e2;
        sb.push_back(exp_of(e2, 32'h0));
        @(negedge clk);
        check_eq("hold_allowin", 192'(ifc.ms_allowin), 192'(0));
        tick();
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = 32'h0BAD_F00D;
        @(negedge clk);
        check_eq("swap_allowin", 192'(ifc.ms_allowin), 192'(1));
        tick();
        ifc.es_to_ms_valid    = 1'b0;
        ifc.data_sram_data_ok = 1'b0;
        ifc.data_sram_rdata   = $urandom;
        @(negedge clk);
        check_eq("swap_next_valid", 192'(ifc.ms_to_ws_valid), 192'(1));
        tick();

        // Reset while busy; a late response must not resurrect the pair.
        e = mk(5'd13, 32'h3000_0000, 5'd14, 32'h66, 1'b1, 3'd5);
        send(e, 32'h0);
        reset          = 1'b1;
        ifc.ws_allowin = 1'b0;
        tick();
        reset = 1'b0;
        sb.delete();
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = 32'h7777_7777;
        @(negedge clk);
        check_eq("rstmid_valid", 192'(ifc.ms_to_ws_valid), 192'(0));
        check_eq("rstmid_allowin", 192'(ifc.ms_allowin), 192'(1));
        tick();
        ifc.data_sram_data_ok = 1'b0;
        ifc.ws_allowin        = 1'b1;
        @(negedge clk);
        check_eq("rstmid_buf", 192'(dut.buf_valid), 192'(0));
        check_eq("rstmid_valid2", 192'(ifc.ms_to_ws_valid), 192'(0));
        tick();

        // Random loads with mixed latency and write-back stalls.
        for (int n = 0; n < 12; n++) begin
            do_load(3'($urandom_range(1, 7)), 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 1));
        end

        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        check_eq("sb_drain", 192'(sb.size()), 192'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
